// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions for the sequential decryptor: controller state
// encoding, S-box tables and the GF(2^8) helpers used by the inverse round
// and the key schedule.
package aes128_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_KEXP,
      ST_ROUND,
      ST_DONE
   } state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

   // Multiply by x modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Exact inverse of xtime: divide by x, folding the reduction back in when odd
   function automatic logic [7:0] inv_xtime(input logic [7:0] b);
      logic [7:0] t;
      t = b[0] ? (b ^ 8'h1b) : b;
      return {b[0], t[7:1]};
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

   // State byte r+4c sits at bits [127-8(r+4c) -: 8]; row r rotates right by r
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage

// File: rtl/aes128_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and, except
// on the final round, InvMixColumns. Purely combinational.
module aes128_inv_round
   import aes128_pkg::*;
(
   input  logic [127:0] st_in,
   input  logic [127:0] rk_in,
   input  logic         last,
   output logic [127:0] st_out
);

   logic [127:0] shifted;
   logic [127:0] subbed;
   logic [127:0] keyed;

   // Apply the inverse round transforms in order, skipping the column mix on the last round
   always_comb begin
      shifted = inv_shift_rows(st_in);
      subbed  = '0;
      for (int i = 0; i < 16; i++) begin
         subbed[127 - 8 * i -: 8] = inv_sbox(shifted[127 - 8 * i -: 8]);
      end
      keyed  = subbed ^ rk_in;
      st_out = keyed;
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            st_out[127 - 32 * c -: 32] = inv_mix_column(keyed[127 - 32 * c -: 32]);
         end
      end
   end

endmodule

// File: rtl/aes128_dec_seq.sv
// Iterative AES-128 decryptor. The key schedule is first run forward to the
// last round key, then unwound one step per inverse round, so only one round
// key register is needed. One SubWord lookup is shared by both directions.
module aes128_dec_seq
   import aes128_pkg::*;
#(
   parameter int NR    = 10,
   parameter int KEY_W = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [127:0]     in,
   input  logic [KEY_W-1:0] k,
   output logic [127:0]     out,
   output logic             ready,
   output logic             busy,
   output logic             done
);

   // cnt runs 1..NR for the forward key steps, NR+1 marks the whitening cycle
   localparam logic [3:0] CNT_KEY_LAST = 4'(NR);
   localparam logic [3:0] CNT_WHITEN   = 4'(NR + 1);
   localparam logic [3:0] CNT_ROUND1   = 4'(NR - 1);

   state_t        state;
   logic [127:0]  st;
   logic [127:0]  rk;
   logic [7:0]    rc;
   logic [3:0]    cnt;

   logic [31:0]   w0, w1, w2, w3;
   logic [31:0]   sub_in, sub_out;
   logic [31:0]   f0, f1, f2, f3;
   logic [31:0]   p0, p1, p2, p3;
   logic [127:0]  rk_fwd;
   logic [127:0]  rk_prev;
   logic [127:0]  round_out;

   // Forward and inverse key steps; the SubWord operand is the current last word
   // going forward and the recovered previous last word going backward
   always_comb begin
      w0 = rk[127:96];
      w1 = rk[95:64];
      w2 = rk[63:32];
      w3 = rk[31:0];
      p3 = w3 ^ w2;
      p2 = w2 ^ w1;
      p1 = w1 ^ w0;
      sub_in  = (state == ST_ROUND) ? p3 : w3;
      sub_out = sub_word(rot_word(sub_in));
      f0 = w0 ^ sub_out ^ {rc, 24'h000000};
      f1 = w1 ^ f0;
      f2 = w2 ^ f1;
      f3 = w3 ^ f2;
      p0 = w0 ^ sub_out ^ {rc, 24'h000000};
      rk_fwd  = {f0, f1, f2, f3};
      rk_prev = {p0, p1, p2, p3};
   end

   aes128_inv_round u_round (
      .st_in  (st),
      .rk_in  (rk_prev),
      .last   (cnt == 4'd0),
      .st_out (round_out)
   );

   // Controller and datapath registers: accept, expand key, whiten, run inverse rounds, publish
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         st    <= '0;
         rk    <= '0;
         rc    <= 8'h00;
         cnt   <= 4'd0;
         out   <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
         ready <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  st    <= in;
                  rk    <= k;
                  rc    <= 8'h01;
                  cnt   <= 4'd1;
                  state <= ST_KEXP;
                  busy  <= 1'b1;
                  ready <= 1'b0;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  ready <= 1'b1;
               end
            end
            ST_KEXP: begin
               if (cnt == CNT_WHITEN) begin
                  st    <= st ^ rk;
                  cnt   <= CNT_ROUND1;
                  state <= ST_ROUND;
               end else begin
                  rk  <= rk_fwd;
                  cnt <= cnt + 4'd1;
                  if (cnt != CNT_KEY_LAST) rc <= xtime(rc);
               end
            end
            ST_ROUND: begin
               st <= round_out;
               rk <= rk_prev;
               rc <= inv_xtime(rc);
               if (cnt == 4'd0) begin
                  out   <= round_out;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
